// File: rtl/rnn_pkg.sv
// Shared definitions for the weight RAM, dot-product units and the weight loader:
// default array geometry, loader state encoding and a width helper.
package rnn_pkg;

    localparam int DEF_NROW     = 16;
    localparam int DEF_NCOL     = 16;
    localparam int DEF_BITWIDTH = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } load_state_t;

    // Ceiling log2, floored at 1 so a single-entry dimension still gets a legal width.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Weight stream (valid/ready) plus RAM column-write bus of the weight loader.
// master = loader side, slave = stream source / RAM side.
interface weight_loader_if
    import rnn_pkg::*;
#(
    parameter int NROW          = DEF_NROW,
    parameter int NCOL          = DEF_NCOL,
    parameter int BITWIDTH      = DEF_BITWIDTH,
    parameter int ADDR_BITWIDTH = clog2(NCOL)
);
    logic [BITWIDTH-1:0]      dataIn;
    logic                     dataValid;
    logic                     dataReady;
    logic [BITWIDTH*NROW-1:0] rowIn;
    logic [ADDR_BITWIDTH-1:0] addressIn;
    logic                     writeEn;

    modport master (
        input  dataIn,
        input  dataValid,
        output dataReady,
        output rowIn,
        output addressIn,
        output writeEn
    );

    modport slave (
        output dataIn,
        output dataValid,
        input  dataReady,
        input  rowIn,
        input  addressIn,
        input  writeEn
    );
endinterface

// File: rtl/loader_column_buf.sv
// NROW x BITWIDTH column assembly register file: one indexed word write per cycle,
// whole column presented flat with slot 0 in the LSBs.
module loader_column_buf
    import rnn_pkg::*;
#(
    parameter  int NROW         = DEF_NROW,
    parameter  int BITWIDTH     = DEF_BITWIDTH,
    localparam int IDX_BITWIDTH = clog2(NROW)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [IDX_BITWIDTH-1:0]  wr_idx,
    input  logic [BITWIDTH-1:0]      wr_data,
    output logic [BITWIDTH*NROW-1:0] row_flat
);
    logic [NROW-1:0][BITWIDTH-1:0] slots_r;

    // Slot storage; a partial column is simply overwritten by the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slots_r <= '0;
        end else if (wr_en) begin
            slots_r[wr_idx] <= wr_data;
        end
    end

    assign row_flat = slots_r;
endmodule

// File: rtl/weight_loader.sv
// Weight RAM writer: assembles NROW streamed words per column and issues NCOL column writes.
// Optional LOADER_CHECKSUM_EN adds a modulo-2^BITWIDTH sum of all words accepted since start.
module weight_loader
    import rnn_pkg::*;
#(
    parameter  int NROW          = DEF_NROW,
    parameter  int NCOL          = DEF_NCOL,
    parameter  int BITWIDTH      = DEF_BITWIDTH,
    localparam int ADDR_BITWIDTH = clog2(NCOL)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    weight_loader_if.master bus,
    output logic            busy,
    output logic            done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [BITWIDTH-1:0] checksum
`endif
);
    localparam int WORD_BITWIDTH = clog2(NROW);
    localparam logic [WORD_BITWIDTH-1:0] LAST_WORD = WORD_BITWIDTH'(NROW - 1);
    localparam logic [ADDR_BITWIDTH-1:0] LAST_COL  = ADDR_BITWIDTH'(NCOL - 1);

    load_state_t              state_r;
    load_state_t              state_next_s;
    logic                     accept_s;
    logic [WORD_BITWIDTH-1:0] word_r;
    logic [ADDR_BITWIDTH-1:0] col_r;
    logic [ADDR_BITWIDTH-1:0] addr_r;
    logic                     ready_r;
    logic                     write_r;
    logic                     busy_r;
    logic                     done_r;

    // Next-state decode; terminal compares are against N-1 so any NROW/NCOL works.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                accept_s = bus.dataValid;
                if (bus.dataValid && (word_r == LAST_WORD)) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_WRITE: begin
                if (col_r == LAST_COL) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register with outputs decoded from the next state so they launch from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
            write_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_FILL);
            write_r <= (state_next_s == ST_WRITE);
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Word/column counters; the write address is latched as the last word is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_r <= '0;
            col_r  <= '0;
            addr_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        word_r <= '0;
                        col_r  <= '0;
                    end
                end
                ST_FILL: begin
                    if (bus.dataValid) begin
                        if (word_r == LAST_WORD) begin
                            addr_r <= col_r;
                        end else begin
                            word_r <= word_r + WORD_BITWIDTH'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    word_r <= '0;
                    if (col_r != LAST_COL) begin
                        col_r <= col_r + ADDR_BITWIDTH'(1);
                    end
                end
                default: begin
                    word_r <= word_r;
                end
            endcase
        end
    end

    loader_column_buf #(
        .NROW     (NROW),
        .BITWIDTH (BITWIDTH)
    ) u_column_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (accept_s),
        .wr_idx   (word_r),
        .wr_data  (bus.dataIn),
        .row_flat (bus.rowIn)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [BITWIDTH-1:0] sum_r;

    // Running sum of accepted words, restarted when a new load is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_r <= '0;
        end else if ((state_r == ST_IDLE) && start) begin
            sum_r <= '0;
        end else if (accept_s) begin
            sum_r <= sum_r + bus.dataIn;
        end
    end

    assign checksum = sum_r;
`endif

    assign bus.dataReady = ready_r;
    assign bus.writeEn   = write_r;
    assign bus.addressIn = addr_r;
    assign busy          = busy_r;
    assign done          = done_r;
endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader (NROW=4, NCOL=4, BITWIDTH=18); checksum checks
// are compiled in when LOADER_CHECKSUM_EN is defined.
module tb_weight_loader;

    typedef struct {
        logic [1:0]  addr;
        logic [71:0] row;
    } wr_t;

    logic clk;
    logic reset;
    logic start;
    logic busy;
    logic done;
`ifdef LOADER_CHECKSUM_EN
    logic [17:0] checksum;
    logic [17:0] exp_sum;
`endif

    int  n_checks;
    int  n_pass;
    int  done_cnt;
    int  busy_cycles;
    wr_t exp_q[$];
    wr_t mon_e;

    weight_loader_if #(.NROW(4), .NCOL(4), .BITWIDTH(18)) wl_bus ();

    weight_loader #(
        .NROW     (4),
        .NCOL     (4),
        .BITWIDTH (18)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (wl_bus),
        .busy  (busy),
        .done  (done)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every RAM write and counts done/busy cycles.
    always @(negedge clk) begin
        if (!reset) begin
            if (wl_bus.writeEn) begin
                check("ready_write_exclusive", {127'd0, wl_bus.dataReady}, 128'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: got write to col %0d, expected none", wl_bus.addressIn);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_addr", {126'd0, wl_bus.addressIn}, {126'd0, mon_e.addr});
                    check("write_row", {56'd0, wl_bus.rowIn}, {56'd0, mon_e.row});
                end
            end
            if (done) begin
                done_cnt++;
`ifdef LOADER_CHECKSUM_EN
                check("checksum", {110'd0, checksum}, {110'd0, exp_sum});
`endif
            end
            if (busy) begin
                busy_cycles++;
            end
        end
    end

    // Present one word and hold it until the loader has taken it; optional idle cycle after.
    task automatic send_word(input logic [17:0] w, input bit gap);
        int guard;
        guard = 0;
        wl_bus.dataIn    = w;
        wl_bus.dataValid = 1'b1;
        while (!wl_bus.dataReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            $display("FAIL ready_timeout: got dataReady=0 for %0d cycles, expected 1", guard);
        end
        @(negedge clk);
        if (gap) begin
            wl_bus.dataValid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic push_col(input int c, input logic [17:0] first, input logic [17:0] step);
        wr_t e;
        logic [17:0] w;
        e.addr = 2'(c);
        e.row  = 72'd0;
        for (int k = 0; k < 4; k++) begin
            w = first + step * 18'(4 * c + k);
            e.row[k*18 +: 18] = w;
        end
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input bit hold);
        start = 1'b1;
        @(negedge clk);
        if (!hold) begin
            start = 1'b0;
        end
    endtask

    // Full 16-word load with words first, first+step, ...; exp_busy=0 skips the busy-length check.
    task automatic run_load(input logic [17:0] first, input logic [17:0] step,
                            input bit gap, input bit spam, input int exp_busy);
        int d0;
        int b0;
        int guard;
        for (int c = 0; c < 4; c++) begin
            push_col(c, first, step);
        end
`ifdef LOADER_CHECKSUM_EN
        exp_sum = 18'd0;
        for (int i = 0; i < 16; i++) begin
            exp_sum = exp_sum + first + step * 18'(i);
        end
`endif
        d0 = done_cnt;
        b0 = busy_cycles;
        pulse_start(spam);
        for (int i = 0; i < 16; i++) begin
            send_word(first + step * 18'(i), gap);
        end
        start            = 1'b0;
        wl_bus.dataValid = 1'b0;
        guard = 0;
        while (done_cnt == d0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            n_checks++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected one", guard);
        end
        repeat (4) @(negedge clk);
        check("done_pulses", 128'(done_cnt - d0), 128'd1);
        check("busy_after_done", {127'd0, busy}, 128'd0);
        check("all_writes_seen", 128'(exp_q.size()), 128'd0);
        if (exp_busy > 0) begin
            check("busy_cycles", 128'(busy_cycles - b0), 128'(exp_busy));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_dataReady"}, {127'd0, wl_bus.dataReady}, 128'd0);
        check({tag, "_writeEn"}, {127'd0, wl_bus.writeEn}, 128'd0);
        check({tag, "_busy"}, {127'd0, busy}, 128'd0);
        check({tag, "_done"}, {127'd0, done}, 128'd0);
        check({tag, "_rowIn"}, {56'd0, wl_bus.rowIn}, 128'd0);
        check({tag, "_addressIn"}, {126'd0, wl_bus.addressIn}, 128'd0);
    endtask

    initial begin
        n_checks         = 0;
        n_pass           = 0;
        done_cnt         = 0;
        busy_cycles      = 0;
        reset            = 1'b1;
        start            = 1'b0;
        wl_bus.dataIn    = 18'd0;
        wl_bus.dataValid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        exp_sum = 18'd0;
`endif
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;

        // Valid data with no start must not be consumed.
        wl_bus.dataIn    = 18'h1234;
        wl_bus.dataValid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle_dataReady", {127'd0, wl_bus.dataReady}, 128'd0);
            check("idle_rowIn", {56'd0, wl_bus.rowIn}, 128'd0);
        end
        wl_bus.dataValid = 1'b0;
        @(negedge clk);

        // Back-to-back 1..16: columns {4c+4,4c+3,4c+2,4c+1}, busy for 4*5+1 cycles.
        run_load(18'd1, 18'd1, 1'b0, 1'b0, 21);

        // dataValid toggling: same contents, nothing dropped or duplicated.
        run_load(18'd1, 18'd1, 1'b1, 1'b0, 0);

        // Reset in the middle of column 1: only column 0 may have been written.
        push_col(0, 18'd1, 18'd1);
        pulse_start(1'b0);
        for (int i = 0; i < 6; i++) begin
            send_word(18'(i + 1), 1'b0);
        end
        wl_bus.dataValid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_zero_outputs("midreset");
        check("midreset_col0_written", 128'(exp_q.size()), 128'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_idle_writeEn", {127'd0, wl_bus.writeEn}, 128'd0);
        run_load(18'd100, 18'd3, 1'b0, 1'b0, 21);

        // start held high through FILL and WRITE is ignored.
        run_load(18'h20000, 18'd7, 1'b0, 1'b1, 21);

        // All-ones words exercise the full word width (checksum wraps to 0x3FFF0).
        run_load(18'h3FFFF, 18'd0, 1'b0, 1'b0, 21);

        check("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
